// File: rtl/nerv_pkg.sv
// nerv_pkg: shared types and constants for the nerv lock driver
package nerv_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_STROBE,
        RD_SAMPLE,
        RESP,
        LOCKOUT
    } nerv_drv_state_t;

    typedef enum logic {
        OP_VERIFY = 1'b0,
        OP_ENROLL = 1'b1
    } nerv_op_t;

    localparam logic [15:0] LOCK_MATCH        = 16'h0001;
    localparam logic        PASS_SLOT_STORED  = 1'b0;
    localparam logic        PASS_SLOT_ATTEMPT = 1'b1;

    // Enroll only when never enrolled or just proven; verify only once something is stored
    function automatic logic req_refused(nerv_op_t op, logic enrolled, logic armed);
        return (op == OP_ENROLL) ? (enrolled & ~armed) : ~enrolled;
    endfunction
endpackage

// File: rtl/nerv_lockout_timer.sv
// nerv_lockout_timer: loadable down-counter whose done flags the last lockout cycle
module nerv_lockout_timer #(
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic done
);
    localparam int CW = $clog2(LOCKOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= CW'(LOCKOUT_CYC);
        else if (cnt != '0) cnt <= cnt - CW'(1);

    assign done = cnt == CW'(1);
endmodule

// File: rtl/nerv_lock_driver.sv
// nerv_lock_driver: request/response front end running nerv enroll/verify bus cycles with lockout
module nerv_lock_driver
    import nerv_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_code,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_match,
    output logic              rsp_err,
    output logic              locked_out,
    output logic [DATA_W-1:0] data_in,
    output logic              pass,
    output logic              cs,
    output logic              write,
    output logic              read,
    input  logic [DATA_W-1:0] lock
);
    localparam int FW = $clog2(MAX_FAILS + 1);

    nerv_drv_state_t state;
    nerv_op_t        op;
    logic            enrolled;
    logic            armed;
    logic [FW-1:0]   fail_cnt;
    logic            hit;
    logic            at_max;
    logic            tmr_load;
    logic            tmr_done;

    assign req_ready = state == IDLE;
    assign hit       = lock == DATA_W'(LOCK_MATCH);
    assign at_max    = fail_cnt == FW'(MAX_FAILS);
    assign tmr_load  = (state == RESP) && rsp_ready && at_max;

    nerv_lockout_timer #(
        .LOCKOUT_CYC(LOCKOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tmr_load),
        .done   (tmr_done)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            op         <= OP_VERIFY;
            enrolled   <= 1'b0;
            armed      <= 1'b0;
            fail_cnt   <= '0;
            rsp_valid  <= 1'b0;
            rsp_match  <= 1'b0;
            rsp_err    <= 1'b0;
            locked_out <= 1'b0;
            data_in    <= '0;
            pass       <= 1'b0;
            cs         <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op <= nerv_op_t'(req_op);
                    if (req_refused(nerv_op_t'(req_op), enrolled, armed)) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        state   <= WR_SETUP;
                        cs      <= 1'b1;
                        data_in <= req_code;
                        pass    <= req_op ? PASS_SLOT_STORED : PASS_SLOT_ATTEMPT;
                    end
                end
                WR_SETUP: begin
                    state <= WR_STROBE;
                    write <= 1'b1;
                end
                WR_STROBE: begin
                    state <= WR_HOLD;
                    write <= 1'b0;
                end
                WR_HOLD: if (op == OP_ENROLL) begin
                    state     <= RESP;
                    cs        <= 1'b0;
                    rsp_valid <= 1'b1;
                    enrolled  <= 1'b1;
                    armed     <= 1'b0;
                    fail_cnt  <= '0;
                end else begin
                    state <= RD_STROBE;
                    read  <= 1'b1;
                end
                RD_STROBE: state <= RD_SAMPLE;
                RD_SAMPLE: begin
                    state     <= RESP;
                    cs        <= 1'b0;
                    read      <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_match <= hit;
                    armed     <= hit;
                    fail_cnt  <= hit ? '0 : at_max ? fail_cnt : fail_cnt + FW'(1);
                end
                RESP: if (rsp_ready) begin
                    rsp_valid  <= 1'b0;
                    rsp_match  <= 1'b0;
                    rsp_err    <= 1'b0;
                    state      <= at_max ? LOCKOUT : IDLE;
                    locked_out <= at_max;
                end
                LOCKOUT: if (tmr_done) begin
                    state      <= IDLE;
                    locked_out <= 1'b0;
                    fail_cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
